// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encoding and FSM states for the iterative mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int OP_W = 7;

    localparam int OP_MUL   = 0;
    localparam int OP_MULH  = 1;
    localparam int OP_MULHU = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_MOD   = 4;
    localparam int OP_DIVU  = 5;
    localparam int OP_MODU  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Operand magnitude extraction and result sign fix-up/selection.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   i_src1,
    input  logic [XLEN-1:0]   i_src2,
    input  logic              i_signed,
    output logic [XLEN-1:0]   o_mag1,
    output logic [XLEN-1:0]   o_mag2,
    output logic              o_neg1,
    output logic              o_neg2,
    input  logic [OP_W-1:0]   i_op,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic              i_neg1,
    input  logic              i_neg2,
    input  logic              i_div_zero,
    output logic [XLEN-1:0]   o_result
);

    localparam int W2 = 2 * XLEN;

    logic            w_neg_pq;
    logic [W2-1:0]   w_prod;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_quot_s;
    logic [XLEN-1:0] w_rem_s;

    assign o_neg1 = i_signed & i_src1[XLEN-1];
    assign o_neg2 = i_signed & i_src2[XLEN-1];
    assign o_mag1 = o_neg1 ? (~i_src1 + XLEN'(1)) : i_src1;
    assign o_mag2 = o_neg2 ? (~i_src2 + XLEN'(1)) : i_src2;

    // Divide leaves the quotient in the low half and the remainder in the high half.
    assign w_neg_pq = i_neg1 ^ i_neg2;
    assign w_prod   = w_neg_pq ? (~i_acc + W2'(1)) : i_acc;
    assign w_quot   = i_acc[XLEN-1:0];
    assign w_rem    = i_acc[W2-1:XLEN];
    assign w_quot_s = w_neg_pq ? (~w_quot + XLEN'(1)) : w_quot;
    assign w_rem_s  = i_neg1 ? (~w_rem + XLEN'(1)) : w_rem;

    // Mod by zero needs no override: a zero divisor lets the remainder collect
    // |src1| unchanged and the dividend-sign fix-up restores src1 exactly.
    always_comb begin
        o_result = '0;
        if (i_op[OP_MUL]) begin
            o_result = w_prod[XLEN-1:0];
        end else if (i_op[OP_MULH] | i_op[OP_MULHU]) begin
            o_result = w_prod[W2-1:XLEN];
        end else if (i_op[OP_DIV]) begin
            o_result = i_div_zero ? '1 : w_quot_s;
        end else if (i_op[OP_DIVU]) begin
            o_result = i_div_zero ? '1 : w_quot;
        end else if (i_op[OP_MOD]) begin
            o_result = w_rem_s;
        end else if (i_op[OP_MODU]) begin
            o_result = w_rem;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative radix-2 multiply/divide unit with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int W2    = 2 * XLEN;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [OP_W-1:0]  op_q,        op_d;
    logic [TAG_W-1:0] tag_q,       tag_d;
    logic [W2-1:0]    acc_q,       acc_d;
    logic [XLEN-1:0]  opnd_q,      opnd_d;
    logic             neg1_q,      neg1_d;
    logic             neg2_q,      neg2_d;
    logic             dz_q,        dz_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  result_q,    result_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic [OP_W-1:0]  w_in_op;
    logic             w_in_signed;
    logic             w_in_div;
    logic             w_busy_div;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic             w_neg1;
    logic             w_neg2;
    logic [XLEN:0]    w_mul_sum;
    logic [W2-1:0]    w_mul_next;
    logic [XLEN:0]    w_part;
    logic [XLEN:0]    w_diff;
    logic             w_ge;
    logic [W2-1:0]    w_div_next;
    logic [W2-1:0]    w_step;
    logic [XLEN-1:0]  w_result;

    // Isolate the lowest set bit so a multi-hot op resolves to one operation.
    assign w_in_op     = in_op & (~in_op + OP_W'(1));
    assign w_in_signed = w_in_op[OP_MULH] | w_in_op[OP_DIV] | w_in_op[OP_MOD];
    assign w_in_div    = |w_in_op[OP_MODU:OP_DIV];
    assign w_busy_div  = |op_q[OP_MODU:OP_DIV];

    assign in_ready   = (state_q == ST_IDLE) && !reset;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_tag    = out_tag_q;

    // Multiply: multiplier sits in the low half and shifts out LSB-first.
    assign w_mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

    // Divide: remainder in the high half, dividend shifts into it MSB-first
    // while quotient bits fill the low half from the right.
    assign w_part     = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    assign w_diff     = w_part - {1'b0, opnd_q};
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_part[XLEN-1:0]), acc_q[XLEN-2:0], w_ge};

    assign w_step = w_busy_div ? w_div_next : w_mul_next;

    muldiv_signfix #(
        .XLEN (XLEN)
    ) u_signfix (
        .i_src1     (in_src1),
        .i_src2     (in_src2),
        .i_signed   (w_in_signed),
        .o_mag1     (w_mag1),
        .o_mag2     (w_mag2),
        .o_neg1     (w_neg1),
        .o_neg2     (w_neg2),
        .i_op       (op_q),
        .i_acc      (w_step),
        .i_neg1     (neg1_q),
        .i_neg2     (neg2_q),
        .i_div_zero (dz_q),
        .o_result   (w_result)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        tag_d       = tag_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        op_d    = w_in_op;
                        tag_d   = in_tag;
                        acc_d   = {{XLEN{1'b0}}, (w_in_div ? w_mag1 : w_mag2)};
                        opnd_d  = w_in_div ? w_mag2 : w_mag1;
                        neg1_d  = w_neg1;
                        neg2_d  = w_neg2;
                        dz_d    = (in_src2 == '0);
                    end
                end
                ST_BUSY: begin
                    acc_d = w_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = w_result;
                        out_tag_d   = tag_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            neg1_q      <= neg1_d;
            neg2_q      <= neg2_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Directed-vector self-checking bench for alu_muldiv (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    localparam logic [6:0] C_MUL   = 7'b0000001;
    localparam logic [6:0] C_MULH  = 7'b0000010;
    localparam logic [6:0] C_MULHU = 7'b0000100;
    localparam logic [6:0] C_DIV   = 7'b0001000;
    localparam logic [6:0] C_MOD   = 7'b0010000;
    localparam logic [6:0] C_DIVU  = 7'b0100000;
    localparam logic [6:0] C_MODU  = 7'b1000000;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_op;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op and return #1 after its acceptance edge (first BUSY cycle).
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 7'd0;
        in_src1  = 32'hDEAD_BEEF;
        in_src2  = 32'h1234_5678;
        in_tag   = 5'd31;
    endtask

    // Entered in cycle 1 after acceptance; waits for out_valid and checks it.
    task automatic wait_result(input string name, input logic [31:0] exp, input logic [4:0] etag);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({name, "_latency"}, 32'(n), 32'd33);
        check_eq({name, "_result"}, out_result, exp);
        check_eq({name, "_tag"}, {27'd0, out_tag}, {27'd0, etag});
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("retire_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        issue(op, a, b, tag);
        wait_result(name, exp, tag);
        retire();
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 7'd0;
        in_src1   = '0;
        in_src2   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", out_result, 32'd0);
        check_eq("rst_tag", {27'd0, out_tag}, 32'd0);
        check_eq("rst_ready_in_reset", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_ready_after", {31'd0, in_ready}, 32'd1);

        run_op("mul",     C_MUL,   32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        run_op("mulh_mm", C_MULH,  32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
        run_op("mulhu",   C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
        run_op("mulh_n",  C_MULH,  32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF);
        run_op("div",     C_DIV,   32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD);
        run_op("mod",     C_MOD,   32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF);
        run_op("divu",    C_DIVU,  32'hFFFF_FFF9, 32'd2,         5'd9,  32'h7FFF_FFFC);
        run_op("modu",    C_MODU,  32'hFFFF_FFF9, 32'd2,         5'd10, 32'd1);
        run_op("div0",    C_DIV,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF);
        run_op("mod0",    C_MOD,   32'd5,         32'd0,         5'd12, 32'd5);
        run_op("modu0",   C_MODU,  32'hFFFF_FFF0, 32'd0,         5'd13, 32'hFFFF_FFF0);
        run_op("divu0",   C_DIVU,  32'd9,         32'd0,         5'd14, 32'hFFFF_FFFF);
        run_op("div_ovf", C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run_op("mod_ovf", C_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
        run_op("op_zero", 7'd0,    32'd100,       32'd7,         5'd17, 32'd0);
        run_op("multihot",7'b0011000, 32'd100,    32'd7,         5'd18, 32'd14);

        // Backpressure: result held for 5 cycles with out_ready low.
        issue(C_DIVU, 32'd100, 32'd7, 5'd19);
        wait_result("bp", 32'd14, 5'd19);
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_result", out_result, 32'd14);
            check_eq("bp_tag", {27'd0, out_tag}, 32'd19);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        retire();
        check_eq("bp_ready_after", {31'd0, in_ready}, 32'd1);

        // Flush during BUSY cycle 10, then a new mulhu must complete cleanly.
        issue(C_MUL, 32'd3, 32'd5, 5'd20);
        n = 1;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        issue(C_MULHU, 32'h0001_0000, 32'h0003_0000, 5'd21);
        wait_result("post_flush", 32'd3, 5'd21);
        retire();

        // Reset while holding a result in DONE.
        issue(C_MOD, 32'd100, 32'd7, 5'd22);
        wait_result("pre_rst", 32'd2, 5'd22);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_done_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_done_result", out_result, 32'd0);
        check_eq("rst_done_tag", {27'd0, out_tag}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_done_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit: the multi-cycle companion of the single-cycle ALU in the execute stage. It executes LoongArch MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU at configurable datapath width. It uses a one-hot operation vector in the same style as the ALU's `alu_op`. A valid/ready handshake on input and output lets the pipeline stall around its XLEN-cycle latency, and `flush` cancels an in-flight operation on exception or branch redirect.

## Interface
- XLEN, 32, operand/result width; even, ≥ 8
- TAG_W, 5, width of the opaque tag carried with each operation (destination register number)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (combinational: state==IDLE && !reset)
- in_op  in  OP_W  one-hot op: [0] mul, [1] mulh, [2] mulhu, [3] div, [4] mod, [5] divu, [6] modu
- in_src1  in  XLEN  rj (multiplicand / dividend)
- in_src2  in  XLEN  rk (multiplier / divisor)
- in_tag  in  TAG_W  returned unchanged with the result
- flush  in  1  cancel any in-flight or pending operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE; out_valid=0, out_result=0, out_tag=0, counter=0.
- IDLE: in_valid && in_ready → latch op, tag, |src1|, |src2| (absolute values for signed ops, raw for unsigned), sign flags; → BUSY, counter=0.
- BUSY: one radix-2 step per cycle.
  - mul: shift-add into a 2·XLEN accumulator.
  - div: restoring division with an XLEN+1-bit partial remainder.
  - counter == XLEN-1 → final step plus sign fix-up, registered into out_result → DONE.
- Sign fix-up:
  - Signed product is negated if operand signs differ.
  - Signed quotient is negated if signs differ.
  - Signed remainder takes the dividend's sign.
  - mul returns the low XLEN bits; mulh/mulhu return the high XLEN bits.
- Divide by zero, overriding the iterative result:
  - div/divu → all ones.
  - mod/modu → src1 unchanged.
- Overflow: div of MIN by -1 → MIN; mod → 0. These results fall out of the unsigned-magnitude algorithm; no special case is needed.
- DONE: out_valid=1; out_result and out_tag are held stable until out_ready. out_valid && out_ready → IDLE.
- in_op all-zero: accepted, result 0 after normal latency. Multi-hot in_op: lowest set bit wins.
- flush (any state) → IDLE next cycle; out_valid deasserts next cycle; no result for the cancelled op. An in_valid in the same cycle as flush is not accepted.
- reset mid-operation: same as flush, and the output registers are also cleared.

## Timing
- Acceptance edge = cycle 0.
- BUSY occupies cycles 1..XLEN.
- out_valid is first high in cycle XLEN+1 (33 for XLEN=32). Latency is fixed for every op, including divide by zero.
- in_ready is low in BUSY and DONE. With out_ready held high, the next acceptance is possible in cycle XLEN+2, so maximum throughput is one op per XLEN+2 cycles.
- out_ready is ignored outside DONE. Output data changes only on entering DONE.
- Counter width is $clog2(XLEN)+1; it never wraps, because it is cleared on acceptance.

## Structure
- Package `muldiv_pkg` holds:
  - OP_W = 7.
  - Op bit-index constants (OP_MUL … OP_MODU).
  - FSM state enum.
- Sub-module `muldiv_signfix` (combinational): abs-value extraction on input and negation/selection on output, shared by both paths.
- Multiply and divide share the datapath registers: a 2·XLEN accumulator and the operand registers.

## Test plan
- mul 7 × 0xFFFFFFFD → 0xFFFFFFEB, out_valid exactly at cycle 33; out_tag equals the in_tag presented at acceptance.
- Multiply-high cases:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulh 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Divide cases:
  - div 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - mod same operands → 0xFFFFFFFF.
  - divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - modu same operands → 1.
- Corner cases:
  - div 5 / 0 → 0xFFFFFFFF; mod 5 / 0 → 5; modu 0xFFFFFFF0 / 0 → 0xFFFFFFF0.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; mod same operands → 0.
- Backpressure: out_ready held low 5 cycles in DONE → out_valid, out_result, out_tag stable and in_ready low; out_ready high → IDLE next cycle, in_ready high.
- Flush/reset:
  - flush at cycle 10 of BUSY → no out_valid ever for that op; in_ready high at cycle 11.
  - A new mulhu accepted then → correct result at +33.
  - reset in DONE → out_valid=0, out_result=0 next cycle.
